// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// control-field encodings and small opcode classification helpers.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JR     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [1:0] RD_R31 = 2'b00;
    localparam logic [1:0] RD_RT  = 2'b01;
    localparam logic [1:0] RD_RD  = 2'b10;

    typedef enum logic [2:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_MEM,
        CL_BRANCH,
        CL_JUMP,
        CL_HALT,
        CL_NOP
    } op_class_e;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       ext_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] reg_dst;
        logic       reg_wre;
        logic       wr_reg_d_src;
        logic       db_data_src;
    } ctrl_t;

    function automatic op_class_e classify(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: return CL_ALU_R;
            OP_ADDI, OP_ORI:                               return CL_ALU_I;
            OP_SW, OP_LW:                                  return CL_MEM;
            OP_BEQ, OP_BNE:                                return CL_BRANCH;
            OP_J, OP_JR, OP_JAL:                           return CL_JUMP;
            OP_HALT:                                       return CL_HALT;
            default:                                       return CL_NOP;
        endcase
    endfunction

    // Address arithmetic for loads/stores shares the adder; branches compare by subtraction.
    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
            OP_OR, OP_ORI:          return ALU_OR;
            OP_AND:                 return ALU_AND;
            OP_SLL:                 return ALU_SLL;
            OP_SLT:                 return ALU_SLT;
            default:                return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit to datapath bundle: instruction fields in, control strobes out.
interface mc_ctrl_if #(
    parameter int OPW = 6,
    parameter int SW  = 3
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic [SW-1:0]  state_o;
    logic           PCWre;
    logic           IRWre;
    logic           InsMemRW;
    logic           ExtSel;
    logic           ALUSrcA;
    logic           ALUSrcB;
    logic [2:0]     ALUOp;
    logic [1:0]     PCSrc;
    logic           mRD;
    logic           mWR;
    logic [1:0]     RegDst;
    logic           RegWre;
    logic           WrRegDSrc;
    logic           DBDataSrc;

    modport master (
        input  opcode, zero,
        output state_o, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
               PCSrc, mRD, mWR, RegDst, RegWre, WrRegDSrc, DBDataSrc
    );

    modport slave (
        output opcode, zero,
        input  state_o, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
               PCSrc, mRD, mWR, RegDst, RegWre, WrRegDSrc, DBDataSrc
    );
endinterface

// File: rtl/mc_control_unit_decode.sv
// Purely combinational strobe decode from (state, opcode, zero).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_e         state,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output ctrl_t          ctrl
);

    op_class_e cls;
    logic      br_taken;

    assign cls      = classify(opcode);
    assign br_taken = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);

    always_comb begin
        ctrl            = '0;
        ctrl.ins_mem_rw = 1'b1;
        // Operand selection depends only on the held opcode, so it is stable from ID to WB.
        ctrl.ext_sel    = !(opcode == OP_ORI || opcode == OP_SLL);
        ctrl.alu_src_a  = (opcode == OP_SLL);
        ctrl.alu_src_b  = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                          (opcode == OP_LW)   || (opcode == OP_SW);
        ctrl.alu_op     = alu_op_of(opcode);

        case (state)
            S_IF: ctrl.ir_wre = 1'b1;
            S_ID: begin
                if (cls == CL_JUMP) begin
                    ctrl.pc_wre = 1'b1;
                    ctrl.pc_src = (opcode == OP_JR) ? PCS_JR : PCS_JUMP;
                    if (opcode == OP_JAL) begin
                        ctrl.reg_wre      = 1'b1;
                        ctrl.reg_dst      = RD_R31;
                        ctrl.wr_reg_d_src = 1'b0;
                    end
                end else if (cls == CL_NOP) begin
                    ctrl.pc_wre = 1'b1;
                end
            end
            S_EXE_BR: begin
                ctrl.pc_wre = 1'b1;
                if (br_taken) ctrl.pc_src = PCS_BRANCH;
            end
            S_MEM: begin
                ctrl.m_rd   = (opcode == OP_LW);
                ctrl.m_wr   = (opcode == OP_SW);
                ctrl.pc_wre = (opcode == OP_SW);
            end
            S_WB_AL: begin
                ctrl.pc_wre       = 1'b1;
                ctrl.reg_wre      = 1'b1;
                ctrl.reg_dst      = (cls == CL_ALU_R) ? RD_RD : RD_RT;
                ctrl.wr_reg_d_src = 1'b1;
            end
            S_WB_LD: begin
                ctrl.pc_wre       = 1'b1;
                ctrl.reg_wre      = 1'b1;
                ctrl.reg_dst      = RD_RT;
                ctrl.db_data_src  = 1'b1;
                ctrl.wr_reg_d_src = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: owns the state register and the sticky halt flag,
// and forces all strobes quiet (except instruction fetch read) during reset.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int SW  = 3
) (
    input  logic         CLK,
    input  logic         RST,
    mc_ctrl_if.master    bus
);

    state_e    state_q, state_d;
    logic      halted_q, halted_d;
    op_class_e cls;
    ctrl_t     dec;
    ctrl_t     ctrl;

    assign cls = classify(bus.opcode);

    mc_ctrl_decode #(.OPW(OPW)) u_decode (
        .state  (state_q),
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .ctrl   (dec)
    );

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            S_IF: if (!halted_q) state_d = S_ID;
            S_ID: begin
                case (cls)
                    CL_ALU_R, CL_ALU_I: state_d = S_EXE_AL;
                    CL_BRANCH:          state_d = S_EXE_BR;
                    CL_MEM:             state_d = S_EXE_LS;
                    CL_HALT: begin
                        state_d  = S_IF;
                        halted_d = 1'b1;
                    end
                    default:            state_d = S_IF;
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (bus.opcode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Halt parks the FSM in IF; suppressing IRWre keeps the halt word in the IR.
    always_comb begin
        ctrl        = dec;
        ctrl.ir_wre = dec.ir_wre & ~halted_q;
        if (RST) begin
            ctrl            = '0;
            ctrl.ins_mem_rw = 1'b1;
        end
    end

    assign bus.state_o   = SW'(state_q);
    assign bus.PCWre     = ctrl.pc_wre;
    assign bus.IRWre     = ctrl.ir_wre;
    assign bus.InsMemRW  = ctrl.ins_mem_rw;
    assign bus.ExtSel    = ctrl.ext_sel;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.PCSrc     = ctrl.pc_src;
    assign bus.mRD       = ctrl.m_rd;
    assign bus.mWR       = ctrl.m_wr;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.RegWre    = ctrl.reg_wre;
    assign bus.WrRegDSrc = ctrl.wr_reg_d_src;
    assign bus.DBDataSrc = ctrl.db_data_src;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction-level bench for mc_control_unit with a per-cycle compare.
module tb_mc_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mc_ctrl_if #(.OPW(6), .SW(3)) bus();

    mc_control_unit #(.OPW(6), .SW(3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_HALT, K_NOP} kind_e;

    typedef struct {
        int st;
        bit rst;
        bit irwre, pcwre, mrd, mwr, regwre, dbsrc, wrsrc;
        bit srca, srcb, ext, alu_chk;
        int pcsrc, regdst, aluop;
    } exp_t;

    exp_t exp_cur;
    bit   chk_en      = 1'b0;
    bit   prev_regwre = 1'b0;
    int   checks      = 0;
    int   failures    = 0;

    logic [5:0] op_tab [15] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                                6'b110100, 6'b110101, 6'b111000, 6'b111001, 6'b111010};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, ex, $time);
        end
    endtask

    function automatic kind_e kind_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000, 6'b100110: return K_R;
            6'b000010, 6'b010010: return K_I;
            6'b110001: return K_LW;
            6'b110000: return K_SW;
            6'b110100, 6'b110101: return K_BR;
            6'b111000: return K_J;
            6'b111010: return K_JAL;
            6'b111001: return K_JR;
            6'b111111: return K_HALT;
            default:   return K_NOP;
        endcase
    endfunction

    function automatic int cpi(input kind_e kd);
        case (kd)
            K_R, K_I, K_SW: return 4;
            K_LW:           return 5;
            K_BR:           return 3;
            default:        return 2;
        endcase
    endfunction

    function automatic int alu_of(input logic [5:0] op);
        case (op)
            6'b000001, 6'b110100, 6'b110101: return 1;
            6'b010000, 6'b010010:            return 3;
            6'b010001:                       return 4;
            6'b011000:                       return 2;
            6'b100110:                       return 6;
            default:                         return 0;
        endcase
    endfunction

    function automatic int state_at(input kind_e kd, input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (kd)
            K_R, K_I:   return (k == 2) ? 6 : 7;
            K_BR:       return 5;
            K_LW, K_SW: return (k == 2) ? 2 : (k == 3) ? 3 : 4;
            default:    return -1;
        endcase
    endfunction

    // Instruction-level rules: the PC moves on the last cycle, writers write on the last cycle.
    function automatic exp_t model(input logic [5:0] op, input int k, input bit z);
        exp_t  e;
        kind_e kd;
        bit    last;
        kd   = kind_of(op);
        last = (k == cpi(kd) - 1);
        e = '{default: 0};
        e.st      = state_at(kd, k);
        e.irwre   = (k == 0);
        e.pcwre   = last && (kd != K_HALT);
        e.regwre  = last && (kd inside {K_R, K_I, K_LW, K_JAL});
        e.mrd     = (kd == K_LW) && (k == 3);
        e.mwr     = (kd == K_SW) && (k == 3);
        e.dbsrc   = (kd == K_LW) && last;
        if (last) begin
            if (kd == K_J || kd == K_JAL) e.pcsrc = 3;
            else if (kd == K_JR)          e.pcsrc = 2;
            else if (kd == K_BR)          e.pcsrc = ((op == 6'b110100) == z) ? 1 : 0;
        end
        e.regdst  = (kd == K_JAL) ? 0 : (kd == K_R) ? 2 : 1;
        e.wrsrc   = (kd != K_JAL);
        e.alu_chk = (k >= 2);
        e.aluop   = alu_of(op);
        e.srca    = (op == 6'b011000);
        e.srcb    = (op == 6'b000010) || (op == 6'b010010) || (op == 6'b110001) || (op == 6'b110000);
        e.ext     = !((op == 6'b010010) || (op == 6'b011000));
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e = '{default: 0};
        e.rst = 1'b1;
        e.st  = -1;
        return e;
    endfunction

    function automatic exp_t halted_exp();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_cur.st >= 0) chk("state_o", bus.state_o, exp_cur.st);
            chk("InsMemRW", bus.InsMemRW, 1);
            chk("IRWre", bus.IRWre, exp_cur.irwre);
            chk("PCWre", bus.PCWre, exp_cur.pcwre);
            chk("mRD", bus.mRD, exp_cur.mrd);
            chk("mWR", bus.mWR, exp_cur.mwr);
            chk("RegWre", bus.RegWre, exp_cur.regwre);
            chk("PCSrc", bus.PCSrc, exp_cur.pcsrc);
            chk("DBDataSrc", bus.DBDataSrc, exp_cur.dbsrc);
            if (exp_cur.rst) begin
                chk("rst_RegDst", bus.RegDst, 0);
                chk("rst_WrRegDSrc", bus.WrRegDSrc, 0);
                chk("rst_ALUOp", bus.ALUOp, 0);
                chk("rst_ALUSrcA", bus.ALUSrcA, 0);
                chk("rst_ALUSrcB", bus.ALUSrcB, 0);
                chk("rst_ExtSel", bus.ExtSel, 0);
            end else begin
                if (exp_cur.regwre) begin
                    chk("RegDst", bus.RegDst, exp_cur.regdst);
                    chk("WrRegDSrc", bus.WrRegDSrc, exp_cur.wrsrc);
                end
                if (exp_cur.alu_chk) begin
                    chk("ALUOp", bus.ALUOp, exp_cur.aluop);
                    chk("ALUSrcA", bus.ALUSrcA, exp_cur.srca);
                    chk("ALUSrcB", bus.ALUSrcB, exp_cur.srcb);
                    chk("ExtSel", bus.ExtSel, exp_cur.ext);
                end
            end
            if (bus.RegWre === 1'b1) chk("RegWre_consecutive", prev_regwre, 0);
            chk("mRD_mWR_exclusive", bus.mRD & bus.mWR, 0);
            prev_regwre = (bus.RegWre === 1'b1);
        end
    end

    task automatic step(input bit r, input logic [5:0] op, input bit z, input exp_t e);
        @(posedge clk);
        #1;
        rst        = r;
        bus.opcode = op;
        bus.zero   = z;
        exp_cur    = e;
        chk_en     = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input bit z, input int abort_at);
        int n;
        n = cpi(kind_of(op));
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                step(1'b1, op, z, rst_exp());
                return;
            end
            step(1'b0, op, z, model(op, k, z));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        bit         z;
        int         ab;
        bus.opcode = 6'b0;
        bus.zero   = 1'b0;

        step(1'b1, 6'b0, 1'b0, rst_exp());
        step(1'b1, 6'b0, 1'b0, rst_exp());

        // add, with literal pins on the reset-release and writeback cycles
        step(1'b0, 6'b000000, 1'b0, model(6'b000000, 0, 1'b0));
        settle();
        chk("pin_if_state", bus.state_o, 3'b000);
        chk("pin_if_IRWre", bus.IRWre, 1);
        chk("pin_if_PCWre", bus.PCWre, 0);
        chk("pin_if_RegWre", bus.RegWre, 0);
        step(1'b0, 6'b000000, 1'b0, model(6'b000000, 1, 1'b0));
        settle();
        chk("pin_id_state", bus.state_o, 3'b001);
        step(1'b0, 6'b000000, 1'b0, model(6'b000000, 2, 1'b0));
        settle();
        chk("pin_add_exe_state", bus.state_o, 3'b110);
        chk("pin_add_ALUOp", bus.ALUOp, 3'b000);
        step(1'b0, 6'b000000, 1'b0, model(6'b000000, 3, 1'b0));
        settle();
        chk("pin_add_wb_state", bus.state_o, 3'b111);
        chk("pin_add_wb_RegWre", bus.RegWre, 1);
        chk("pin_add_wb_RegDst", bus.RegDst, 2'b10);
        chk("pin_add_wb_PCWre", bus.PCWre, 1);

        run_instr(6'b110001, 1'b0, -1);
        run_instr(6'b110000, 1'b0, -1);
        run_instr(6'b110100, 1'b1, -1);
        run_instr(6'b110100, 1'b0, -1);
        run_instr(6'b110101, 1'b1, -1);
        run_instr(6'b110101, 1'b0, -1);

        step(1'b0, 6'b111010, 1'b0, model(6'b111010, 0, 1'b0));
        step(1'b0, 6'b111010, 1'b0, model(6'b111010, 1, 1'b0));
        settle();
        chk("pin_jal_RegWre", bus.RegWre, 1);
        chk("pin_jal_RegDst", bus.RegDst, 2'b00);
        chk("pin_jal_WrRegDSrc", bus.WrRegDSrc, 0);
        chk("pin_jal_PCSrc", bus.PCSrc, 2'b11);
        chk("pin_jal_PCWre", bus.PCWre, 1);

        run_instr(6'b111000, 1'b0, -1);
        run_instr(6'b111001, 1'b0, -1);
        run_instr(6'b101010, 1'b0, -1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 3) op = 6'($urandom_range(0, 63));
            else                          op = op_tab[$urandom_range(0, 14)];
            if (op == 6'b111111) op = 6'b101010;
            z  = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, cpi(kind_of(op)) - 1)) : -1;
            run_instr(op, z, ab);
        end

        // halt parks the machine; opcode noise must not wake it
        run_instr(6'b111111, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), halted_exp());
        end
        step(1'b1, 6'b111111, 1'b0, rst_exp());
        run_instr(6'b110001, 1'b0, 3);
        run_instr(6'b000000, 1'b0, -1);
        run_instr(6'b110001, 1'b1, -1);

        settle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
